// File: rtl/change_dispenser.sv
// Change dispenser: validates a payment against coin/note stock,
// then ejects the change greedily, one item per ready cycle.
module change_dispenser #(
  parameter int VALUE_W         = 6,
  parameter int COIN_VALUE      = 2,
  parameter int NOTE_VALUE      = 10,
  parameter int STOCK_W         = 6,
  parameter int COIN_STOCK_INIT = 20,
  parameter int NOTE_STOCK_INIT = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [VALUE_W-1:0] value_to_pay,
  input  logic [VALUE_W-1:0] input_money,
  input  logic               dispense_ready,
  input  logic               refill,
  output logic               coin_out,
  output logic               note_out,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         error_code,
  output logic [STOCK_W-1:0] coin_stock,
  output logic [STOCK_W-1:0] note_stock
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DISPENSE
  } state_t;

  localparam logic [31:0] NV = 32'(NOTE_VALUE);
  localparam logic [31:0] CV = 32'(COIN_VALUE);
  localparam logic [STOCK_W-1:0] CS_INIT = STOCK_W'(COIN_STOCK_INIT);
  localparam logic [STOCK_W-1:0] NS_INIT = STOCK_W'(NOTE_STOCK_INIT);
  localparam logic [STOCK_W-1:0] S_ONE = STOCK_W'(1);
  localparam logic [VALUE_W-1:0] V_ONE = VALUE_W'(1);

  state_t state_q, state_d;
  logic [VALUE_W-1:0] change_q, change_d;
  logic [STOCK_W-1:0] notes_q, notes_d;
  logic [VALUE_W-1:0] coins_q, coins_d;
  logic [STOCK_W-1:0] coin_stock_q, coin_stock_d;
  logic [STOCK_W-1:0] note_stock_q, note_stock_d;
  logic coin_out_q, coin_out_d;
  logic note_out_q, note_out_d;
  logic done_q, done_d;
  logic busy_q, busy_d;
  logic error_q, error_d;
  logic [1:0] error_code_q, error_code_d;

  logic [31:0] chg, notes_fit, notes_use;
  logic [31:0] coins_need, rem;
  logic last_item;

  // Greedy split: as many notes as stock allows, remainder in coins.
  always_comb begin
    chg        = 32'(change_q);
    notes_fit  = chg / NV;
    notes_use  = (notes_fit < 32'(note_stock_q)) ?
                 notes_fit : 32'(note_stock_q);
    coins_need = (chg - notes_use * NV) / CV;
    rem        = chg % CV;
  end

  always_comb begin
    state_d      = state_q;
    change_d     = change_q;
    notes_d      = notes_q;
    coins_d      = coins_q;
    coin_stock_d = coin_stock_q;
    note_stock_d = note_stock_q;
    coin_out_d   = 1'b0;
    note_out_d   = 1'b0;
    done_d       = 1'b0;
    error_d      = error_q;
    error_code_d = error_code_q;
    last_item    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (input_money < value_to_pay) begin
            error_d      = 1'b1;
            error_code_d = 2'b01;
          end else begin
            change_d     = input_money - value_to_pay;
            error_d      = 1'b0;
            error_code_d = 2'b00;
            state_d      = CALC;
          end
        end else if (refill) begin
          coin_stock_d = CS_INIT;
          note_stock_d = NS_INIT;
        end
      end
      CALC: begin
        state_d = IDLE;
        if (rem != 32'd0) begin
          error_d      = 1'b1;
          error_code_d = 2'b10;
        end else if (coins_need > 32'(coin_stock_q)) begin
          error_d      = 1'b1;
          error_code_d = 2'b11;
        end else if (change_q == '0) begin
          done_d = 1'b1;
        end else begin
          notes_d = STOCK_W'(notes_use);
          coins_d = VALUE_W'(coins_need);
          state_d = DISPENSE;
        end
      end
      DISPENSE: begin
        if (dispense_ready) begin
          if (notes_q != '0) begin
            note_out_d   = 1'b1;
            notes_d      = notes_q - S_ONE;
            note_stock_d = note_stock_q - S_ONE;
            last_item    = (notes_q == S_ONE) && (coins_q == '0);
          end else begin
            coin_out_d   = 1'b1;
            coins_d      = coins_q - V_ONE;
            coin_stock_d = coin_stock_q - S_ONE;
            last_item    = (coins_q == V_ONE);
          end
          if (last_item) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      change_q     <= '0;
      notes_q      <= '0;
      coins_q      <= '0;
      coin_stock_q <= CS_INIT;
      note_stock_q <= NS_INIT;
      coin_out_q   <= 1'b0;
      note_out_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      error_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      change_q     <= change_d;
      notes_q      <= notes_d;
      coins_q      <= coins_d;
      coin_stock_q <= coin_stock_d;
      note_stock_q <= note_stock_d;
      coin_out_q   <= coin_out_d;
      note_out_q   <= note_out_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
    end
  end

  assign coin_out   = coin_out_q;
  assign note_out   = note_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign error_code = error_code_q;
  assign coin_stock = coin_stock_q;
  assign note_stock = note_stock_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized
// transactions against a greedy-change reference model.
module tb_change_dispenser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [5:0] value_to_pay = '0;
  logic [5:0] input_money = '0;
  logic       dispense_ready = 1'b0;
  logic       refill = 1'b0;

  logic       coin_out, note_out, busy, done, error;
  logic [1:0] error_code;
  logic [5:0] coin_stock, note_stock;

  logic       coin_out2, note_out2, busy2, done2, error2;
  logic [1:0] error_code2;
  logic [5:0] coin_stock2, note_stock2;

  int checks = 0;
  int failures = 0;

  int mcoin, mnote;

  string obs_s;
  int    done_cnt, done_iter, first_iter;
  bit    done_with_last, both, bad_ready, timeout;

  always #5 clock = ~clock;

  change_dispenser dut (
    .clock(clock), .reset(reset), .start(start),
    .value_to_pay(value_to_pay), .input_money(input_money),
    .dispense_ready(dispense_ready), .refill(refill),
    .coin_out(coin_out), .note_out(note_out), .busy(busy),
    .done(done), .error(error), .error_code(error_code),
    .coin_stock(coin_stock), .note_stock(note_stock)
  );

  change_dispenser #(.COIN_STOCK_INIT(1), .NOTE_STOCK_INIT(1)) dut2 (
    .clock(clock), .reset(reset), .start(start2),
    .value_to_pay(value_to_pay), .input_money(input_money),
    .dispense_ready(dispense_ready), .refill(refill),
    .coin_out(coin_out2), .note_out(note_out2), .busy(busy2),
    .done(done2), .error(error2), .error_code(error_code2),
    .coin_stock(coin_stock2), .note_stock(note_stock2)
  );

  // Reference: greedy change from the denomination rules.
  task automatic model(input int pay, input int money,
                       output int code, output string s);
    int ch, n, c;
    s = "";
    code = 0;
    if (money < pay) begin
      code = 1;
      return;
    end
    ch = money - pay;
    if (ch % 2 != 0) begin
      code = 2;
      return;
    end
    n = ch / 10;
    if (n > mnote) n = mnote;
    c = (ch - n * 10) / 2;
    if (c > mcoin) begin
      code = 3;
      return;
    end
    for (int i = 0; i < n; i++) s = {s, "N"};
    for (int i = 0; i < c; i++) s = {s, "C"};
    mnote -= n;
    mcoin -= c;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    refill = 1'b0;
    dispense_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    mcoin = 20;
    mnote = 5;
  endtask

  // Drives one transaction and records what the DUT ejected.
  task automatic run_txn(input int pay, input int money,
                         input int mode, input bit spam);
    bit rdy;
    obs_s = "";
    done_cnt = 0;
    done_iter = -1;
    first_iter = -1;
    done_with_last = 0;
    both = 0;
    bad_ready = 0;
    timeout = 0;
    @(negedge clock);
    value_to_pay = 6'(pay);
    input_money = 6'(money);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; ; i++) begin
      if (!busy) break;
      if (i >= 300) begin
        timeout = 1;
        break;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (i % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      dispense_ready = rdy;
      if (spam) begin
        start = 1'b1;
        value_to_pay = 6'($urandom);
        input_money = 6'($urandom);
      end
      @(negedge clock);
      if (coin_out && note_out) both = 1;
      if ((coin_out || note_out) && !rdy) bad_ready = 1;
      if ((coin_out || note_out) && first_iter < 0) first_iter = i;
      if (note_out) obs_s = {obs_s, "N"};
      else if (coin_out) obs_s = {obs_s, "C"};
      if (done) begin
        done_cnt++;
        done_iter = i;
        done_with_last = coin_out || note_out;
      end
    end
    start = 1'b0;
    dispense_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (coin_stock !== 6'd20 || note_stock !== 6'd5) begin
      failures++;
      $display("FAIL reset_stock got=%0d/%0d exp=20/5",
               coin_stock, note_stock);
    end
    checks++;
    if ({busy, done, error, coin_out, note_out} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {busy, done, error, coin_out, note_out});
    end
    checks++;
    if (error_code !== 2'b00) begin
      failures++;
      $display("FAIL reset_code got=%b exp=00", error_code);
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_txn(14, 30, 0, 0);
    checks++;
    if (obs_s != "NCCC") begin
      failures++;
      $display("FAIL basic_seq got=%s exp=NCCC", obs_s);
    end
    checks++;
    if (first_iter != 1 || done_iter != 4) begin
      failures++;
      $display("FAIL basic_latency got=%0d/%0d exp=1/4",
               first_iter, done_iter);
    end
    checks++;
    if (done_cnt != 1 || !done_with_last) begin
      failures++;
      $display("FAIL basic_done got=%0d/%0d exp=1/1",
               done_cnt, done_with_last);
    end
    checks++;
    if (note_stock !== 6'd4 || coin_stock !== 6'd17) begin
      failures++;
      $display("FAIL basic_stock got=%0d/%0d exp=4/17",
               note_stock, coin_stock);
    end
  endtask

  task automatic test_exact();
    do_reset();
    run_txn(20, 20, 0, 0);
    checks++;
    if (obs_s != "" || done_cnt != 1 || done_iter != 0) begin
      failures++;
      $display("FAIL exact got=%s/%0d/%0d exp=none/1/0",
               obs_s, done_cnt, done_iter);
    end
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL exact_error got=%b exp=0", error);
    end
  endtask

  task automatic test_underpaid();
    do_reset();
    run_txn(16, 10, 0, 0);
    @(negedge clock);
    checks++;
    if (error !== 1'b1 || error_code !== 2'b01) begin
      failures++;
      $display("FAIL underpaid got=%b/%b exp=1/01",
               error, error_code);
    end
    checks++;
    if (busy !== 1'b0 || obs_s != "") begin
      failures++;
      $display("FAIL underpaid_busy got=%b/%s exp=0/none",
               busy, obs_s);
    end
    checks++;
    if (coin_stock !== 6'd20 || note_stock !== 6'd5) begin
      failures++;
      $display("FAIL underpaid_stock got=%0d/%0d exp=20/5",
               coin_stock, note_stock);
    end
  endtask

  task automatic test_insufficient();
    bit pulse;
    do_reset();
    pulse = 0;
    @(negedge clock);
    value_to_pay = 6'd0;
    input_money = 6'd24;
    start2 = 1'b1;
    dispense_ready = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    pulse |= coin_out2 | note_out2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      pulse |= coin_out2 | note_out2;
    end
    dispense_ready = 1'b0;
    checks++;
    if (error2 !== 1'b1 || error_code2 !== 2'b11) begin
      failures++;
      $display("FAIL insufficient got=%b/%b exp=1/11",
               error2, error_code2);
    end
    checks++;
    if (pulse || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL insufficient_pulse got=%b/%b exp=0/0",
               pulse, busy2);
    end
    checks++;
    if (coin_stock2 !== 6'd1 || note_stock2 !== 6'd1) begin
      failures++;
      $display("FAIL insufficient_stock got=%0d/%0d exp=1/1",
               coin_stock2, note_stock2);
    end
  endtask

  task automatic test_ready_toggle();
    do_reset();
    run_txn(4, 30, 1, 1);
    checks++;
    if (obs_s != "NNCCC") begin
      failures++;
      $display("FAIL toggle_seq got=%s exp=NNCCC", obs_s);
    end
    checks++;
    if (bad_ready || both || timeout) begin
      failures++;
      $display("FAIL toggle_ready got=%b%b%b exp=000",
               bad_ready, both, timeout);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      failures++;
      $display("FAIL toggle_spam got=%b/%0d exp=0/1",
               busy, done_cnt);
    end
    checks++;
    if (note_stock !== 6'd3 || coin_stock !== 6'd17) begin
      failures++;
      $display("FAIL toggle_stock got=%0d/%0d exp=3/17",
               note_stock, coin_stock);
    end
  endtask

  task automatic test_reset_mid();
    int  cnt;
    bit  pulse;
    do_reset();
    cnt = 0;
    pulse = 0;
    @(negedge clock);
    value_to_pay = 6'd14;
    input_money = 6'd30;
    start = 1'b1;
    dispense_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      @(negedge clock);
      if (coin_out || note_out) cnt++;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (cnt != 2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset got=%0d/%b exp=2/0", cnt, busy);
    end
    checks++;
    if (coin_stock !== 6'd20 || note_stock !== 6'd5) begin
      failures++;
      $display("FAIL midreset_stock got=%0d/%0d exp=20/5",
               coin_stock, note_stock);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      pulse |= coin_out | note_out | done;
    end
    dispense_ready = 1'b0;
    checks++;
    if (pulse) begin
      failures++;
      $display("FAIL midreset_quiet got=%b exp=0", pulse);
    end
    run_txn(14, 30, 0, 0);
    @(negedge clock);
    refill = 1'b1;
    @(negedge clock);
    refill = 1'b0;
    checks++;
    if (coin_stock !== 6'd20 || note_stock !== 6'd5) begin
      failures++;
      $display("FAIL refill got=%0d/%0d exp=20/5",
               coin_stock, note_stock);
    end
  endtask

  task automatic test_random();
    int    pay, money, code;
    string exp_s;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        refill = 1'b1;
        @(negedge clock);
        refill = 1'b0;
        mcoin = 20;
        mnote = 5;
      end
      pay = $urandom_range(0, 40);
      money = $urandom_range(0, 63);
      model(pay, money, code, exp_s);
      run_txn(pay, money, 2, 1'($urandom_range(0, 1)));
      checks++;
      if (obs_s != exp_s || timeout) begin
        failures++;
        $display("FAIL rand_seq t=%0d got=%s exp=%s", t, obs_s, exp_s);
      end
      checks++;
      if (error_code !== 2'(code) || error !== (code != 0)) begin
        failures++;
        $display("FAIL rand_code t=%0d got=%b/%b exp=%0d",
                 t, error, error_code, code);
      end
      checks++;
      if (coin_stock !== 6'(mcoin) || note_stock !== 6'(mnote)) begin
        failures++;
        $display("FAIL rand_stock t=%0d got=%0d/%0d exp=%0d/%0d",
                 t, coin_stock, note_stock, mcoin, mnote);
      end
      checks++;
      if (done_cnt != ((code == 0) ? 1 : 0) || bad_ready || both) begin
        failures++;
        $display("FAIL rand_done t=%0d got=%0d/%b/%b exp=%0d/0/0",
                 t, done_cnt, bad_ready, both, (code == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exact();
    test_underpaid();
    test_insufficient();
    test_ready_toggle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
